// File: rtl/gates_pkg.sv
// Shared types and defaults for the gates_pipe boolean-result pipeline.
// Result fields are sized for the widest legal operand; narrower pipes use the low bits.
package gates_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 64;

    typedef struct packed {
        logic [MAX_W-1:0] y1;
        logic [MAX_W-1:0] y2;
        logic [MAX_W-1:0] y3;
        logic [MAX_W-1:0] y4;
        logic [MAX_W-1:0] y5;
        logic             all_zero;
    } gates_result_t;
endpackage

// File: rtl/gates_pipe_if.sv
// Operand/result handshake bundle for gates_pipe.
// The producer/consumer side uses the master modport, and the pipeline uses the slave modport.
interface gates_pipe_if
    import gates_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] y4;
    logic [WIDTH-1:0] y5;
    logic             all_zero;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y1, y2, y3, y4, y5, all_zero, count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y1, y2, y3, y4, y5, all_zero, count
    );
endinterface

// File: rtl/gates_stage.sv
// One valid/ready register slice.
// The slice can accept new data whenever it is empty or is being drained on the same edge.
module gates_stage
    import gates_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    // Data only moves on a real transfer, so an empty or stalled slice keeps its last contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/gates_pipe.sv
// Two-stage pipeline: S1 registers a/b, and S2 registers AND/OR/XOR/NAND/NOR plus the all-zero flag.
// It also counts completed output handshakes with a saturating counter.
module gates_pipe
    import gates_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    gates_pipe_if.slave  bus
);
    logic               s1_valid;
    logic               s2_ready;
    logic [2*WIDTH-1:0] s1_q;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [WIDTH-1:0]   and_ab;
    logic [WIDTH-1:0]   or_ab;
    gates_result_t      res;
    gates_result_t      s2_q;
    logic [CNT_W-1:0]   count_q;
    logic               s2_unused;

    gates_stage #(.DATA_W(2*WIDTH)) u_s1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  ({bus.a, bus.b}),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_q)
    );

    assign {s1_a, s1_b} = s1_q;
    assign and_ab = s1_a & s1_b;
    assign or_ab  = s1_a | s1_b;

    // Boolean results are formed between the stages; unused upper field bits stay zero.
    always_comb begin
        res                 = '0;
        res.y1[WIDTH-1:0]   = and_ab;
        res.y2[WIDTH-1:0]   = or_ab;
        res.y3[WIDTH-1:0]   = s1_a ^ s1_b;
        res.y4[WIDTH-1:0]   = ~and_ab;
        res.y5[WIDTH-1:0]   = ~or_ab;
        res.all_zero        = ~|and_ab;
    end

    gates_stage #(.DATA_W($bits(gates_result_t))) u_s2 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  (res),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (s2_q)
    );

    assign bus.y1       = s2_q.y1[WIDTH-1:0];
    assign bus.y2       = s2_q.y2[WIDTH-1:0];
    assign bus.y3       = s2_q.y3[WIDTH-1:0];
    assign bus.y4       = s2_q.y4[WIDTH-1:0];
    assign bus.y5       = s2_q.y5[WIDTH-1:0];
    assign bus.all_zero = s2_q.all_zero;
    assign s2_unused    = ^s2_q;

    // The counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (bus.out_valid && bus.out_ready && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_gates_pipe.sv
// Directed bench for gates_pipe: narrow, saturating-counter and wide instances share clock and reset.
// Expected result sets are written as {y1,y2,y3,y4,y5,all_zero}.
module tb_gates_pipe;
    import gates_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gates_pipe_if #(.WIDTH(4),  .CNT_W(8)) bus4 ();
    gates_pipe_if #(.WIDTH(4),  .CNT_W(2)) bus_sat ();
    gates_pipe_if #(.WIDTH(16), .CNT_W(8)) bus16 ();

    gates_pipe #(.WIDTH(4),  .CNT_W(8)) dut4    (.clk(clk), .reset(reset), .bus(bus4));
    gates_pipe #(.WIDTH(4),  .CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(bus_sat));
    gates_pipe #(.WIDTH(16), .CNT_W(8)) dut16   (.clk(clk), .reset(reset), .bus(bus16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.in_valid = 1'b0;    bus4.a = '0;    bus4.b = '0;    bus4.out_ready = 1'b0;
        bus_sat.in_valid = 1'b0; bus_sat.a = '0; bus_sat.b = '0; bus_sat.out_ready = 1'b0;
        bus16.in_valid = 1'b0;   bus16.a = '0;   bus16.b = '0;   bus16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus4.out_valid);
        end
        checks++;
        if ({bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== 21'h0) begin
            errors++; $display("[TB] FAIL reset_results got %h want 000000",
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero});
        end
        checks++;
        if (bus4.count !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_count got %0d want 0", bus4.count);
        end
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus4.in_ready);
        end
        checks++;
        if (bus16.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_wide_out_valid got %b want 0", bus16.out_valid);
        end
    endtask

    task automatic test_single();
        bus4.out_ready = 1'b1;
        bus4.a = 4'b0001; bus4.b = 4'b0000; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_early_valid got %b want 0", bus4.out_valid);
        end
        tick();
        checks++;
        if (bus4.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL single_out_valid got %b want 1", bus4.out_valid);
        end
        checks++;
        if ({bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !==
            {4'b0000, 4'b0001, 4'b0001, 4'b1111, 4'b1110, 1'b1}) begin
            errors++; $display("[TB] FAIL single_results got %b want %b",
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero},
                {4'b0000, 4'b0001, 4'b0001, 4'b1111, 4'b1110, 1'b1});
        end
        tick();
        checks++;
        if (bus4.count !== 8'd1) begin
            errors++; $display("[TB] FAIL single_count got %0d want 1", bus4.count);
        end
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_drained got %b want 0", bus4.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  av [3] = '{4'b0000, 4'b0001, 4'b0000};
        logic [3:0]  bv [3] = '{4'b0001, 4'b0001, 4'b0000};
        logic [20:0] ev [3] = '{
            {4'b0000, 4'b0001, 4'b0001, 4'b1111, 4'b1110, 1'b1},
            {4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b1110, 1'b0},
            {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1}};
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                bus4.a = av[i]; bus4.b = bv[i]; bus4.in_valid = 1'b1;
            end else begin
                bus4.in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus4.out_valid !== 1'b1 ||
                    {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== ev[i-1]) begin
                    errors++; $display("[TB] FAIL b2b_result%0d got v=%b %b want v=1 %b", i - 1,
                        bus4.out_valid, {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero},
                        ev[i-1]);
                end
            end
        end
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.count !== 8'd4) begin
            errors++; $display("[TB] FAIL b2b_drain got v=%b count=%0d want v=0 count=4",
                bus4.out_valid, bus4.count);
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] eq0 = {4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 1'b0};
        logic [20:0] eq1 = {4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 1'b0};
        logic [20:0] eq2 = {4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1};
        bus4.out_ready = 1'b0;
        bus4.a = 4'b0011; bus4.b = 4'b0101; bus4.in_valid = 1'b1;
        tick();
        bus4.a = 4'b1100; bus4.b = 4'b1010;
        tick();
        bus4.a = 4'b1111; bus4.b = 4'b0000;
        checks++;
        if (bus4.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full_in_ready got %b want 0", bus4.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus4.out_valid !== 1'b1 ||
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== eq0) begin
                errors++; $display("[TB] FAIL bp_hold%0d got v=%b %b want v=1 %b", i, bus4.out_valid,
                    {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero}, eq0);
            end
            if (i < 2) tick();
        end
        checks++;
        if (bus4.in_ready !== 1'b0 || bus4.count !== 8'd4) begin
            errors++; $display("[TB] FAIL bp_stalled got in_ready=%b count=%0d want 0 and 4",
                bus4.in_ready, bus4.count);
        end
        bus4.out_ready = 1'b1;
        #1;
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release_in_ready got %b want 1", bus4.in_ready);
        end
        tick();
        bus4.in_valid = 1'b0;
        checks++;
        if ({bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== eq1) begin
            errors++; $display("[TB] FAIL bp_second got %b want %b",
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero}, eq1);
        end
        tick();
        checks++;
        if (bus4.out_valid !== 1'b1 ||
            {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== eq2) begin
            errors++; $display("[TB] FAIL bp_third got v=%b %b want v=1 %b", bus4.out_valid,
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero}, eq2);
        end
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.count !== 8'd7) begin
            errors++; $display("[TB] FAIL bp_drain got v=%b count=%0d want v=0 count=7",
                bus4.out_valid, bus4.count);
        end
    endtask

    task automatic test_reset_mid_flight();
        bus4.out_ready = 1'b1;
        bus4.a = 4'b0101; bus4.b = 4'b0011; bus4.in_valid = 1'b1;
        tick();
        bus4.a = 4'b0110; bus4.b = 4'b0110;
        tick();
        bus4.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.count !== 8'd0 || bus4.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_state got v=%b count=%0d in_ready=%b want 0 0 1",
                bus4.out_valid, bus4.count, bus4.in_ready);
        end
        checks++;
        if ({bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !== 21'h0) begin
            errors++; $display("[TB] FAIL midreset_results got %h want 000000",
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero});
        end
        bus4.a = 4'b1111; bus4.b = 4'b1010; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        checks++;
        if (bus4.out_valid !== 1'b1 ||
            {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero} !==
            {4'b1010, 4'b1111, 4'b0101, 4'b0101, 4'b0000, 1'b0}) begin
            errors++; $display("[TB] FAIL midreset_first got v=%b %b want v=1 %b", bus4.out_valid,
                {bus4.y1, bus4.y2, bus4.y3, bus4.y4, bus4.y5, bus4.all_zero},
                {4'b1010, 4'b1111, 4'b0101, 4'b0101, 4'b0000, 1'b0});
        end
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.count !== 8'd1) begin
            errors++; $display("[TB] FAIL midreset_drain got v=%b count=%0d want v=0 count=1",
                bus4.out_valid, bus4.count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus_sat.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_sat.in_valid = (i < 5);
            bus_sat.a = 4'(i);
            bus_sat.b = 4'hF;
            tick();
            if (i >= 2 && i <= 6) begin
                checks++;
                if (bus_sat.count !== exp_cnt[i-2]) begin
                    errors++; $display("[TB] FAIL sat_count%0d got %0d want %0d", i - 2,
                        bus_sat.count, exp_cnt[i-2]);
                end
            end
        end
        checks++;
        if (bus_sat.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL sat_drain got %b want 0", bus_sat.out_valid);
        end
    endtask

    task automatic test_wide();
        logic [80:0] ew = {16'h00FF, 16'hFFFF, 16'hFF00, 16'hFF00, 16'h0000, 1'b0};
        bus16.out_ready = 1'b1;
        bus16.a = 16'hFFFF; bus16.b = 16'h00FF; bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick();
        checks++;
        if (bus16.out_valid !== 1'b1 ||
            {bus16.y1, bus16.y2, bus16.y3, bus16.y4, bus16.y5, bus16.all_zero} !== ew) begin
            errors++; $display("[TB] FAIL wide_results got v=%b %h want v=1 %h", bus16.out_valid,
                {bus16.y1, bus16.y2, bus16.y3, bus16.y4, bus16.y5, bus16.all_zero}, ew);
        end
        tick();
        checks++;
        if (bus16.count !== 8'd1) begin
            errors++; $display("[TB] FAIL wide_count got %0d want 1", bus16.count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_flight();
        test_saturation();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
